pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Controller for the CPU program counter. It sequences every PC update: plain increment, absolute jump operand fetch, relative branch with page-cross fix-up, and RESET/NMI/IRQ vector fetch. It drives the counter's increment, hold and load enables and the ADL/ADH load bytes, and it issues the memory reads those sequences need. It sits between instruction decode (the command source) and the program counter.

## Interface
Parameters: none.
- sys_clock  in  1  system clock
- reset  in  1  synchronous, active-low
- clk_ph2_enable  in  1  phase-2 step strobe; state advances and PC latches only when high
- pc_lo, pc_hi  in  8 each  current PC from the counter
- data_in  in  8  read data; valid on the step after the step that issued mem_rd
- cmd_valid  in  1  command request
- cmd  in  3  0 INC, 1 JMP_ABS, 2 BRANCH, 3 VEC_RESET, 4 VEC_NMI, 5 VEC_IRQ, 6-7 reserved
- branch_offset  in  8  signed relative offset
- branch_taken  in  1  branch condition result
- cmd_ready  out  1  high only in IDLE
- done  out  1  step-qualified pulse on the final step of a command
- page_cross  out  1  step-qualified pulse on the branch fix-up step
- pc_inc_en, pcl_hold, pch_hold, adl_load, adh_load  out  1 each  program counter controls
- adl_out, adh_out  out  8 each  load bytes for the PC
- mem_addr  out  16  read address; mem_rd  out  1  read request

## Operation
- Counter semantics on each step:
  - The low byte selects the current PCL when pcl_hold=1, else adl_out when adl_load=1.
  - The high byte selects the same way using pch_hold, adh_out and adh_load.
  - PC latches the selected value plus 1 if pc_inc_en=1, otherwise the selected value unchanged.
- Default outputs: pcl_hold=pch_hold=1; all other controls 0; mem_addr=0; adl_out=adh_out=0.
- Outputs are combinational from the state, the temp register and the inputs.
- States: BOOT, IDLE, JMP_LO, JMP_HI, BR_FIX, VEC_LO, VEC_HI. Registers: temp[7:0], vec[15:0], fix_dir.
- A command is accepted when the step is high, cmd_valid=1 and the state is IDLE. In any other state cmd_valid is ignored.
- IDLE with no command: PC holds.
- INC: pc_inc_en=1, done. Stay in IDLE.
- JMP_ABS:
  - IDLE step: mem_addr={pc_hi,pc_lo}, mem_rd=1, pc_inc_en=1. Go to JMP_LO.
  - JMP_LO: temp<=data_in, mem_addr=PC, mem_rd=1, pc_inc_en=1. Go to JMP_HI.
  - JMP_HI: adl_out=temp, adh_out=data_in, adl_load=adh_load=1, holds=0, done. Go to IDLE.
- BRANCH, not taken: PC holds, done, stay in IDLE.
- BRANCH, taken:
  - Compute the 9-bit sum {c,s}=pc_lo+branch_offset (unsigned add).
  - Load the low byte: adl_out=s, adl_load=1, pcl_hold=0.
  - A page cross occurs when (offset[7]=0 and c=1) or (offset[7]=1 and c=0).
  - No cross: done, stay in IDLE.
  - Cross: fix_dir<=offset[7]; go to BR_FIX.
- BR_FIX:
  - adh_out=pc_hi+1 if fix_dir=0, else pc_hi-1 (mod 256).
  - adh_load=1, pch_hold=0, page_cross, done. Go to IDLE.
- VEC_x: vec is FFFC for RESET, FFFA for NMI, FFFE for IRQ.
  - IDLE step: mem_addr=vec, mem_rd=1, PC holds. Go to VEC_LO.
  - VEC_LO: temp<=data_in, mem_addr=vec+1, mem_rd=1. Go to VEC_HI.
  - VEC_HI: adl_out=temp, adh_out=data_in, both loads, holds=0, done. Go to IDLE.
- BOOT: behaves as an accepted VEC_RESET (mem_addr=FFFC, mem_rd=1, vec<=FFFC), then goes to VEC_LO. cmd_ready=0.
- Reserved commands: PC holds, done, stay in IDLE.
- Wrap-around: 16-bit increments wrap FFFF to 0000 inside the counter. pc_hi+/-1 wraps mod 256.

## Timing
- Reset low at any sys_clock edge, in any state and regardless of the step strobe:
  - state<=BOOT, temp<=0, vec<=FFFC, fix_dir<=0.
  - Outputs while in BOOT: mem_rd=1, mem_addr=FFFC, pcl_hold=pch_hold=1, everything else 0.
- Reset mid-command aborts the command. No done pulse is issued.
- When clk_ph2_enable=0: state and registers hold; done=page_cross=0; the other outputs stay stable.
- Step latency per command:
  - INC, not-taken BRANCH, reserved: 1 step.
  - Taken BRANCH without page cross: 1 step.
  - Taken BRANCH with page cross: 2 steps.
  - JMP_ABS and VEC_x: 3 steps.
  - Boot to first IDLE: 3 steps.
- cmd_ready returns high on the step after done.

## Test plan
- Reset, then 3 steps with data_in 00 then 80 -> PC=8000, done on step 3, cmd_ready=1 on step 4.
- JMP_ABS at PC=8000, reads return 34 then 12 -> mem_addr 8000, then 8001; PC=1234 after 3 steps.
- BRANCH taken, PC=80F0, offset 20 -> PCL=10, then BR_FIX with page_cross=1 -> PC=8110.
- BRANCH taken, PC=8010, offset F0 -> PC=8000 in 1 step, page_cross=0. Offset E0 -> PC=7FF0 in 2 steps.
- NMI vector: reads return CD then AB -> mem_addr FFFA, then FFFB; PC=ABCD.
- INC at PC=FFFF -> PC=0000. Reset asserted in JMP_HI -> state BOOT, no done, PC unchanged.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter update sequencer (increment, jump, branch, vectors)
module pc_sequencer (
    input  logic        sys_clock,
    input  logic        reset,
    input  logic        clk_ph2_enable,
    input  logic [7:0]  pc_lo,
    input  logic [7:0]  pc_hi,
    input  logic [7:0]  data_in,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd,
    input  logic [7:0]  branch_offset,
    input  logic        branch_taken,
    output logic        cmd_ready,
    output logic        done,
    output logic        page_cross,
    output logic        pc_inc_en,
    output logic        pcl_hold,
    output logic        pch_hold,
    output logic        adl_load,
    output logic        adh_load,
    output logic [7:0]  adl_out,
    output logic [7:0]  adh_out,
    output logic [15:0] mem_addr,
    output logic        mem_rd
);

    typedef enum logic [2:0] {
        BOOT, IDLE, JMP_LO, JMP_HI, BR_FIX, VEC_LO, VEC_HI
    } state_t;

    state_t      state, state_nxt, state_dec;
    logic [7:0]  temp, temp_nxt;
    logic [15:0] vec, vec_nxt;
    logic        fix_dir, fix_dir_nxt;
    logic        done_raw, cross_raw;
    logic [8:0]  br_sum;
    logic        br_cross;
    logic [15:0] cmd_vec;

    assign br_sum   = {1'b0, pc_lo} + {1'b0, branch_offset};
    assign br_cross = branch_offset[7] ^ br_sum[8];
    assign cmd_vec  = (cmd == 3'd4) ? 16'hFFFA : (cmd == 3'd5) ? 16'hFFFE : 16'hFFFC;

    // While reset is held the outputs already look like BOOT, so an aborted
    // command can neither pulse done nor disturb the counter.
    assign state_dec = reset ? state : BOOT;

    always_ff @(posedge sys_clock) begin
        if (!reset) begin
            state   <= BOOT;
            temp    <= 8'h00;
            vec     <= 16'hFFFC;
            fix_dir <= 1'b0;
        end else if (clk_ph2_enable) begin
            state   <= state_nxt;
            temp    <= temp_nxt;
            vec     <= vec_nxt;
            fix_dir <= fix_dir_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        temp_nxt    = temp;
        vec_nxt     = vec;
        fix_dir_nxt = fix_dir;
        cmd_ready   = 1'b0;
        done_raw    = 1'b0;
        cross_raw   = 1'b0;
        pc_inc_en   = 1'b0;
        pcl_hold    = 1'b1;
        pch_hold    = 1'b1;
        adl_load    = 1'b0;
        adh_load    = 1'b0;
        adl_out     = 8'h00;
        adh_out     = 8'h00;
        mem_addr    = 16'h0000;
        mem_rd      = 1'b0;
        case (state_dec)
            BOOT: begin
                mem_addr  = 16'hFFFC;
                mem_rd    = 1'b1;
                vec_nxt   = 16'hFFFC;
                state_nxt = VEC_LO;
            end
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd)
                        3'd0: begin
                            pc_inc_en = 1'b1;
                            done_raw  = 1'b1;
                        end
                        3'd1: begin
                            mem_addr  = {pc_hi, pc_lo};
                            mem_rd    = 1'b1;
                            pc_inc_en = 1'b1;
                            state_nxt = JMP_LO;
                        end
                        3'd2: begin
                            if (branch_taken) begin
                                adl_out  = br_sum[7:0];
                                adl_load = 1'b1;
                                pcl_hold = 1'b0;
                                if (br_cross) begin
                                    fix_dir_nxt = branch_offset[7];
                                    state_nxt   = BR_FIX;
                                end else begin
                                    done_raw = 1'b1;
                                end
                            end else begin
                                done_raw = 1'b1;
                            end
                        end
                        3'd3, 3'd4, 3'd5: begin
                            vec_nxt   = cmd_vec;
                            mem_addr  = cmd_vec;
                            mem_rd    = 1'b1;
                            state_nxt = VEC_LO;
                        end
                        default: done_raw = 1'b1;
                    endcase
                end
            end
            JMP_LO: begin
                temp_nxt  = data_in;
                mem_addr  = {pc_hi, pc_lo};
                mem_rd    = 1'b1;
                pc_inc_en = 1'b1;
                state_nxt = JMP_HI;
            end
            JMP_HI, VEC_HI: begin
                adl_out   = temp;
                adh_out   = data_in;
                adl_load  = 1'b1;
                adh_load  = 1'b1;
                pcl_hold  = 1'b0;
                pch_hold  = 1'b0;
                done_raw  = 1'b1;
                state_nxt = IDLE;
            end
            BR_FIX: begin
                adh_out   = fix_dir ? (pc_hi - 8'd1) : (pc_hi + 8'd1);
                adh_load  = 1'b1;
                pch_hold  = 1'b0;
                cross_raw = 1'b1;
                done_raw  = 1'b1;
                state_nxt = IDLE;
            end
            VEC_LO: begin
                temp_nxt  = data_in;
                mem_addr  = vec + 16'd1;
                mem_rd    = 1'b1;
                state_nxt = VEC_HI;
            end
            default: state_nxt = BOOT;
        endcase
    end

    assign done       = done_raw & clk_ph2_enable;
    assign page_cross = cross_raw & clk_ph2_enable;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and randomized bench for pc_sequencer
module tb_pc_sequencer;

    logic        sys_clock = 1'b0;
    logic        reset = 1'b0;
    logic        clk_ph2_enable = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd = 3'd0;
    logic [7:0]  branch_offset = 8'h00;
    logic        branch_taken = 1'b0;
    logic        cmd_ready, done, page_cross, pc_inc_en, pcl_hold, pch_hold;
    logic        adl_load, adh_load, mem_rd;
    logic [7:0]  adl_out, adh_out;
    logic [15:0] mem_addr;

    logic [15:0] pc = 16'h5555;
    logic [7:0]  mem [0:65535];

    int tests = 0;
    int fails = 0;

    logic        s_done, s_cross, s_rd;
    logic [15:0] s_addr;

    pc_sequencer dut (
        .sys_clock(sys_clock), .reset(reset), .clk_ph2_enable(clk_ph2_enable),
        .pc_lo(pc[7:0]), .pc_hi(pc[15:8]), .data_in(data_in),
        .cmd_valid(cmd_valid), .cmd(cmd), .branch_offset(branch_offset),
        .branch_taken(branch_taken), .cmd_ready(cmd_ready), .done(done),
        .page_cross(page_cross), .pc_inc_en(pc_inc_en), .pcl_hold(pcl_hold),
        .pch_hold(pch_hold), .adl_load(adl_load), .adh_load(adh_load),
        .adl_out(adl_out), .adh_out(adh_out), .mem_addr(mem_addr), .mem_rd(mem_rd)
    );

    always #5 sys_clock = ~sys_clock;

    // Program counter and memory as the environment sees them
    always @(posedge sys_clock) begin : env
        logic [15:0] sel;
        if (clk_ph2_enable) begin
            sel[7:0]  = pcl_hold ? pc[7:0]  : (adl_load ? adl_out : pc[7:0]);
            sel[15:8] = pch_hold ? pc[15:8] : (adh_load ? adh_out : pc[15:8]);
            pc <= pc_inc_en ? sel + 16'd1 : sel;
            if (mem_rd) data_in <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        clk_ph2_enable = 1'b1;
        #1;
        s_done  = done;
        s_cross = page_cross;
        s_rd    = mem_rd;
        s_addr  = mem_addr;
        @(posedge sys_clock);
        @(negedge sys_clock);
        clk_ph2_enable = 1'b0;
    endtask

    task automatic stall();
        clk_ph2_enable = 1'b0;
        #1;
        check("stall_done", 32'(done), 32'd0);
        check("stall_cross", 32'(page_cross), 32'd0);
        @(posedge sys_clock);
        @(negedge sys_clock);
    endtask

    task automatic model(input logic [2:0] c, input logic [7:0] off, input logic tk,
                         input logic [15:0] p, output logic [15:0] np, output int st,
                         output logic cr, output int nrd, output logic [15:0] a0,
                         output logic [15:0] a1);
        np = p; st = 1; cr = 1'b0; nrd = 0; a0 = 16'h0; a1 = 16'h0;
        case (c)
            3'd0: np = p + 16'd1;
            3'd1: begin
                a0 = p; a1 = p + 16'd1; nrd = 2; st = 3;
                np = {mem[a1], mem[a0]};
            end
            3'd2: if (tk) begin
                np = p + {{8{off[7]}}, off};
                cr = (np[15:8] != p[15:8]);
                st = cr ? 2 : 1;
            end
            3'd3, 3'd4, 3'd5: begin
                a0 = (c == 3'd3) ? 16'hFFFC : (c == 3'd4) ? 16'hFFFA : 16'hFFFE;
                a1 = a0 + 16'd1; nrd = 2; st = 3;
                np = {mem[a1], mem[a0]};
            end
            default: ;
        endcase
    endtask

    task automatic run_cmd(input string tag, input logic [2:0] c, input logic [7:0] off,
                           input logic tk, input logic random_stalls);
        logic [15:0] exp_pc, a0, a1;
        logic [15:0] rds [$];
        int   exp_st, exp_nrd, n;
        logic exp_cr, got_cr, finished;
        model(c, off, tk, pc, exp_pc, exp_st, exp_cr, exp_nrd, a0, a1);
        cmd = c; branch_offset = off; branch_taken = tk; cmd_valid = 1'b1;
        #1;
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        n = 0; got_cr = 1'b0; finished = 1'b0;
        while (!finished && n < 8) begin
            step();
            cmd_valid = 1'b0;
            n++;
            if (s_rd) rds.push_back(s_addr);
            if (s_cross) got_cr = 1'b1;
            if (s_done) finished = 1'b1;
            else if (random_stalls && $urandom_range(0, 2) == 0) stall();
        end
        check({tag, "_done_seen"}, 32'(finished), 32'd1);
        check({tag, "_steps"}, 32'(n), 32'(exp_st));
        check({tag, "_pc"}, 32'(pc), 32'(exp_pc));
        check({tag, "_cross"}, 32'(got_cr), 32'(exp_cr));
        check({tag, "_nreads"}, 32'(rds.size()), 32'(exp_nrd));
        if (rds.size() == 2 && exp_nrd == 2) begin
            check({tag, "_rd0"}, 32'(rds[0]), 32'(a0));
            check({tag, "_rd1"}, 32'(rds[1]), 32'(a1));
        end
    endtask

    task automatic boot(input string tag);
        step();
        check({tag, "_s1_addr"}, 32'(s_addr), 32'hFFFC);
        check({tag, "_s1_done"}, 32'(s_done), 32'd0);
        step();
        check({tag, "_s2_addr"}, 32'(s_addr), 32'hFFFD);
        check({tag, "_s2_done"}, 32'(s_done), 32'd0);
        step();
        check({tag, "_s3_done"}, 32'(s_done), 32'd1);
        check({tag, "_pc"}, 32'(pc), 32'h8000);
    endtask

    initial begin
        logic [15:0] pc_before;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
        mem[16'h8000] = 8'h34; mem[16'h8001] = 8'h12;
        mem[16'h1234] = 8'hF0; mem[16'h1235] = 8'h80;
        mem[16'h8110] = 8'h10; mem[16'h8111] = 8'h80;
        mem[16'hFFFA] = 8'hCD; mem[16'hFFFB] = 8'hAB;
        mem[16'hABCD] = 8'hFF; mem[16'hABCE] = 8'hFF;

        // Reset held with the step strobe high must still leave BOOT outputs
        @(negedge sys_clock);
        reset = 1'b0; clk_ph2_enable = 1'b1;
        @(negedge sys_clock);
        @(negedge sys_clock);
        #1;
        check("rst_mem_rd", 32'(mem_rd), 32'd1);
        check("rst_mem_addr", 32'(mem_addr), 32'hFFFC);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_holds", 32'({pcl_hold, pch_hold}), 32'd3);
        check("rst_loads", 32'({pc_inc_en, adl_load, adh_load, page_cross}), 32'd0);
        check("rst_pc", 32'(pc), 32'h5555);
        @(negedge sys_clock);
        clk_ph2_enable = 1'b0;
        reset = 1'b1;

        boot("boot");
        run_cmd("jmp_8000", 3'd1, 8'h00, 1'b0, 1'b0);
        check("jmp_pc_1234", 32'(pc), 32'h1234);
        run_cmd("jmp_to_80f0", 3'd1, 8'h00, 1'b0, 1'b0);
        run_cmd("br_fwd_cross", 3'd2, 8'h20, 1'b1, 1'b1);
        check("br_pc_8110", 32'(pc), 32'h8110);
        run_cmd("jmp_to_8010", 3'd1, 8'h00, 1'b0, 1'b0);
        run_cmd("br_back_nocross", 3'd2, 8'hF0, 1'b1, 1'b0);
        check("br_pc_8000", 32'(pc), 32'h8000);
        run_cmd("br_fwd_nocross", 3'd2, 8'h10, 1'b1, 1'b0);
        run_cmd("br_back_cross", 3'd2, 8'hE0, 1'b1, 1'b0);
        check("br_pc_7ff0", 32'(pc), 32'h7FF0);
        run_cmd("br_not_taken", 3'd2, 8'h55, 1'b0, 1'b0);
        run_cmd("reserved6", 3'd6, 8'h00, 1'b0, 1'b0);
        run_cmd("nmi", 3'd4, 8'h00, 1'b0, 1'b1);
        check("nmi_pc_abcd", 32'(pc), 32'hABCD);
        run_cmd("jmp_to_ffff", 3'd1, 8'h00, 1'b0, 1'b0);
        run_cmd("inc_wrap", 3'd0, 8'h00, 1'b0, 1'b0);
        check("inc_pc_0000", 32'(pc), 32'h0000);

        // Abort a jump in its final state
        cmd = 3'd1; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        pc_before = pc;
        reset = 1'b0; clk_ph2_enable = 1'b1;
        #1;
        check("abort_done", 32'(done), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd0);
        check("abort_loads", 32'({adl_load, adh_load}), 32'd0);
        @(posedge sys_clock);
        @(negedge sys_clock);
        check("abort_pc", 32'(pc), 32'(pc_before));
        clk_ph2_enable = 1'b0;
        reset = 1'b1;
        boot("reboot");

        for (int i = 0; i < 80; i++) begin
            run_cmd("rand", 3'($urandom_range(0, 7)), 8'($urandom),
                    1'($urandom_range(0, 1)), 1'b1);
            if ($urandom_range(0, 3) == 0) stall();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
